// File: rtl/axil_axis_responder.sv
// AXI4-Lite register slave plus AXI-Stream endpoint: buffers ss words in a FIFO
// and emits their running prefix sum on sm, with tlast on the final word of a run.
module axil_axis_responder #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pFIFO_DEPTH = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast
);

  localparam int FIFO_AW = $clog2(pFIFO_DEPTH);

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL  = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN   = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] ADDR_COUNT = pADDR_WIDTH'(20);

  typedef enum logic {W_ADDR, W_DATA} w_state_t;
  typedef enum logic {R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {E_IDLE, E_RUN, E_DONE} e_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  e_state_t e_state_q, e_state_d;

  logic [pADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [pADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d;
  logic [pDATA_WIDTH-1:0] length_q, length_d;

  logic [pDATA_WIDTH-1:0] acc_q, acc_d;
  logic [pDATA_WIDTH-1:0] count_q, count_d;
  logic                   sm_tvalid_q, sm_tvalid_d;
  logic [pDATA_WIDTH-1:0] sm_tdata_q, sm_tdata_d;
  logic                   sm_tlast_q, sm_tlast_d;

  logic [FIFO_AW:0]       wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]       rd_ptr_q, rd_ptr_d;
  logic [pDATA_WIDTH-1:0] fifo_mem [pFIFO_DEPTH];

  logic                   wr_commit;
  logic                   rd_done_clr;
  logic [pDATA_WIDTH-1:0] reg_rd_val;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [pDATA_WIDTH-1:0] fifo_head, acc_sum;
  logic                   start_go, done_set, sm_fire;

  // Stream tlast on the input side carries no meaning here; the run length comes from the register.
  logic unused_ss_tlast;
  assign unused_ss_tlast = ss_tlast;

  // ---------------- write channel FSM ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      w_state_q <= W_ADDR;
      waddr_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    case (w_state_q)
      W_ADDR: if (awvalid) begin
        waddr_d   = awaddr;
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid) w_state_d = W_ADDR;
      default: w_state_d = W_ADDR;
    endcase
  end

  always_comb begin
    awready   = (w_state_q == W_ADDR);
    wready    = (w_state_q == W_DATA);
    wr_commit = (w_state_q == W_DATA) && wvalid;
  end

  // ---------------- read channel FSM ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state_q <= R_ADDR;
      raddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    reg_rd_val = '0;
    case (araddr)
      ADDR_CTRL:  reg_rd_val = {{(pDATA_WIDTH-3){1'b0}}, ap_idle_q, ap_done_q, ap_start_q};
      ADDR_LEN:   reg_rd_val = length_q;
      ADDR_COUNT: reg_rd_val = count_q;
      default:    reg_rd_val = '0;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_ADDR: if (arvalid) begin
        raddr_d   = araddr;
        rdata_d   = reg_rd_val;
        r_state_d = R_DATA;
      end
      R_DATA: if (rready) begin
        rdata_d   = '0;
        r_state_d = R_ADDR;
      end
      default: r_state_d = R_ADDR;
    endcase
  end

  always_comb begin
    arready     = (r_state_q == R_ADDR);
    rvalid      = (r_state_q == R_DATA);
    rd_done_clr = (r_state_q == R_DATA) && rready && (raddr_q == ADDR_CTRL);
  end

  assign rdata = rdata_q;

  // ---------------- ss input FIFO ----------------
  assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == (FIFO_AW+1)'(pFIFO_DEPTH));
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_push  = ss_tvalid && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
  assign ss_tready  = !fifo_full;
  assign wr_ptr_d   = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Storage carries no reset; emptiness is defined by the pointers alone.
  always_ff @(posedge wb_clk_i) begin
    if (fifo_push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= ss_tdata;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ---------------- engine FSM ----------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) e_state_q <= E_IDLE;
    else          e_state_q <= e_state_d;
  end

  assign sm_fire = sm_tvalid_q && sm_tready;

  always_comb begin
    e_state_d = e_state_q;
    case (e_state_q)
      E_IDLE:  if (ap_start_q) e_state_d = (length_q == '0) ? E_DONE : E_RUN;
      E_RUN:   if (sm_fire && sm_tlast_q) e_state_d = E_DONE;
      E_DONE:  e_state_d = E_IDLE;
      default: e_state_d = E_IDLE;
    endcase
  end

  // Pop only while words of this run remain; the output register must be free or draining.
  always_comb begin
    start_go = (e_state_q == E_IDLE) && ap_start_q;
    done_set = (e_state_q != E_DONE) && (e_state_d == E_DONE);
    fifo_pop = (e_state_q == E_RUN) && !fifo_empty && (count_q != length_q)
               && (!sm_tvalid_q || sm_tready);
  end

  assign acc_sum = acc_q + fifo_head;

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    sm_tvalid_d = sm_tvalid_q;
    sm_tdata_d  = sm_tdata_q;
    sm_tlast_d  = sm_tlast_q;
    if (start_go) begin
      acc_d   = '0;
      count_d = '0;
    end else if (fifo_pop) begin
      acc_d       = acc_sum;
      count_d     = count_q + pDATA_WIDTH'(1);
      sm_tvalid_d = 1'b1;
      sm_tdata_d  = acc_sum;
      sm_tlast_d  = (count_q == length_q - pDATA_WIDTH'(1));
    end else if (sm_fire) begin
      sm_tvalid_d = 1'b0;
    end
  end

  // Control registers: a done set in the same cycle as a clear-on-read wins.
  always_comb begin
    ap_start_d = ap_start_q;
    ap_idle_d  = ap_idle_q;
    ap_done_d  = ap_done_q;
    length_d   = length_q;
    if (start_go)
      ap_start_d = 1'b0;
    else if (wr_commit && waddr_q == ADDR_CTRL && wdata[0] && ap_idle_q)
      ap_start_d = 1'b1;
    if (wr_commit && waddr_q == ADDR_LEN && ap_idle_q)
      length_d = wdata;
    if (done_set)      ap_idle_d = 1'b1;
    else if (start_go) ap_idle_d = 1'b0;
    if (done_set)                     ap_done_d = 1'b1;
    else if (start_go || rd_done_clr) ap_done_d = 1'b0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ap_start_q  <= 1'b0;
      ap_done_q   <= 1'b0;
      ap_idle_q   <= 1'b1;
      length_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      sm_tvalid_q <= 1'b0;
      sm_tdata_q  <= '0;
      sm_tlast_q  <= 1'b0;
    end else begin
      ap_start_q  <= ap_start_d;
      ap_done_q   <= ap_done_d;
      ap_idle_q   <= ap_idle_d;
      length_q    <= length_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sm_tvalid_q <= sm_tvalid_d;
      sm_tdata_q  <= sm_tdata_d;
      sm_tlast_q  <= sm_tlast_d;
    end
  end

  assign sm_tvalid = sm_tvalid_q;
  assign sm_tdata  = sm_tdata_q;
  assign sm_tlast  = sm_tlast_q;

endmodule

// File: tb/tb_axil_axis_responder.sv
// Directed bench for axil_axis_responder: expected sm beats and read data are queued
// at stimulus time and checked by an independent monitor on the falling edge.
module tb_axil_axis_responder;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, ss_tdata = '0;
  logic        ss_tvalid = 1'b0, ss_tlast = 1'b0, sm_tready = 1'b1;
  logic        awready, wready, arready, rvalid, ss_tready, sm_tvalid, sm_tlast;
  logic [31:0] rdata, sm_tdata;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] sm_exp_q[$];
  logic [31:0] rd_exp_q[$];

  always #5 wb_clk_i = ~wb_clk_i;

  axil_axis_responder #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .pFIFO_DEPTH(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Monitor: consumes expectations on every handshake and checks sm stability under stall.
  initial begin
    logic        stall_v;
    logic [32:0] stall_d;
    logic [32:0] e;
    stall_v = 1'b0;
    stall_d = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        stall_v = 1'b0;
      end else begin
        if (stall_v) begin
          chk("sm_hold_valid", {31'b0, sm_tvalid}, 32'd1);
          chk("sm_hold_data", sm_tdata, stall_d[31:0]);
          chk("sm_hold_last", {31'b0, sm_tlast}, {31'b0, stall_d[32]});
        end
        if (sm_tvalid && sm_tready) begin
          if (sm_exp_q.size() == 0) begin
            chk("sm_unexpected_beat", sm_tdata, 32'hxxxx_xxxx);
          end else begin
            e = sm_exp_q.pop_front();
            chk("sm_data", sm_tdata, e[31:0]);
            chk("sm_last", {31'b0, sm_tlast}, {31'b0, e[32]});
          end
        end
        stall_v = sm_tvalid && !sm_tready;
        stall_d = {sm_tlast, sm_tdata};
        if (rvalid && rready) begin
          if (rd_exp_q.size() == 0) chk("rd_unexpected", rdata, 32'hxxxx_xxxx);
          else chk("rd_data", rdata, rd_exp_q.pop_front());
        end
      end
    end
  end

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
    logic hs;
    int n;
    awvalid = 1'b1; awaddr = a;
    hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      @(negedge wb_clk_i); hs = awready;
      if (hs) chk("wready_low_in_addr", {31'b0, wready}, 32'd0);
      @(posedge wb_clk_i); #1; n++;
    end
    if (!hs) timeout("aw_handshake");
    awvalid = 1'b0; wvalid = 1'b1; wdata = d;
    hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      @(negedge wb_clk_i); hs = wready;
      @(posedge wb_clk_i); #1; n++;
    end
    if (!hs) timeout("w_handshake");
    wvalid = 1'b0;
  endtask

  task automatic ar_phase(input logic [11:0] a, input logic [31:0] exp);
    logic hs;
    int n;
    rd_exp_q.push_back(exp);
    arvalid = 1'b1; araddr = a;
    hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      @(negedge wb_clk_i); hs = arready;
      @(posedge wb_clk_i); #1; n++;
    end
    if (!hs) timeout("ar_handshake");
    arvalid = 1'b0;
  endtask

  task automatic r_phase();
    logic hs;
    int n;
    rready = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      @(negedge wb_clk_i); hs = rvalid;
      @(posedge wb_clk_i); #1; n++;
    end
    if (!hs) timeout("r_handshake");
    rready = 1'b0;
  endtask

  task automatic axil_read(input logic [11:0] a, input logic [31:0] exp);
    ar_phase(a, exp);
    r_phase();
  endtask

  task automatic ss_push(input logic [31:0] d);
    logic hs;
    int n;
    ss_tvalid = 1'b1; ss_tdata = d;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge wb_clk_i); hs = ss_tready;
      @(posedge wb_clk_i); #1; n++;
    end
    if (!hs) timeout("ss_handshake");
    ss_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sm_exp_q.size() != 0 && n < 300) begin
      @(posedge wb_clk_i); n++;
    end
    if (sm_exp_q.size() != 0) timeout("sm_drain");
    repeat (3) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ctl"}, {25'b0, awready, arready, wready, rvalid, ss_tready, sm_tvalid, sm_tlast},
        32'b1100100);
    chk({name, "_rdata"}, rdata, 32'd0);
    chk({name, "_sm_tdata"}, sm_tdata, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] sum;

    // Reset state
    repeat (2) @(negedge wb_clk_i);
    chk_reset_outs("reset");
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    $display("reset released, outputs checked");

    // Length write/read with rvalid held across stalled rready
    axil_write(12'h010, 32'd5);
    ar_phase(12'h010, 32'd5);
    repeat (3) begin
      @(negedge wb_clk_i);
      chk("rvalid_held", {31'b0, rvalid}, 32'd1);
      chk("rdata_held", rdata, 32'd5);
      @(posedge wb_clk_i); #1;
    end
    r_phase();
    @(negedge wb_clk_i);
    chk("rvalid_after", {31'b0, rvalid}, 32'd0);
    chk("rdata_after", rdata, 32'd0);
    @(posedge wb_clk_i); #1;
    $display("txn: length=5 write/read with 3-cycle rready stall");

    // Basic run: 1,2,3,4 -> 1,3,6,10
    axil_write(12'h010, 32'd4);
    axil_write(12'h000, 32'd1);
    sm_exp_q.push_back({1'b0, 32'd1});
    sm_exp_q.push_back({1'b0, 32'd3});
    sm_exp_q.push_back({1'b0, 32'd6});
    sm_exp_q.push_back({1'b1, 32'd10});
    for (int i = 1; i <= 4; i++) ss_push(32'(i));
    wait_drain();
    axil_read(12'h014, 32'd4);
    axil_read(12'h000, 32'h6);
    axil_read(12'h000, 32'h4);
    axil_read(12'h020, 32'h0);
    $display("txn: length=4 prefix-sum run, done clear-on-read");

    // Prefetch fills FIFO; 9th word refused; then 8 back-to-back beats
    for (int i = 1; i <= 8; i++) ss_push(32'(i));
    ss_tvalid = 1'b1; ss_tdata = 32'd99;
    repeat (2) begin
      @(negedge wb_clk_i);
      chk("ss_tready_full", {31'b0, ss_tready}, 32'd0);
      @(posedge wb_clk_i); #1;
    end
    ss_tvalid = 1'b0;
    axil_write(12'h010, 32'd8);
    sum = 0;
    for (int i = 1; i <= 8; i++) begin
      sum = sum + 32'(i);
      sm_exp_q.push_back({(i == 8), sum});
    end
    axil_write(12'h000, 32'd1);
    n = 0;
    do begin
      @(negedge wb_clk_i); n++;
    end while (!sm_tvalid && n < 20);
    if (!sm_tvalid) timeout("first_beat");
    for (int i = 0; i < 8; i++) begin
      chk("no_bubble", {31'b0, sm_tvalid}, 32'd1);
      @(negedge wb_clk_i);
    end
    @(posedge wb_clk_i); #1;
    wait_drain();
    axil_read(12'h000, 32'h6);
    $display("txn: prefetched 8 words, full back-pressure, 8 beats no bubbles");

    // Wraparound with sm_tready toggling
    axil_write(12'h010, 32'd3);
    axil_write(12'h000, 32'd1);
    sm_exp_q.push_back({1'b0, 32'hFFFF_FFFF});
    sm_exp_q.push_back({1'b0, 32'h0000_0000});
    sm_exp_q.push_back({1'b1, 32'h0000_0002});
    sm_tready = 1'b0;
    fork
      begin
        ss_push(32'hFFFF_FFFF);
        ss_push(32'd1);
        ss_push(32'd2);
      end
      begin
        repeat (16) begin
          @(posedge wb_clk_i); #1;
          sm_tready = ~sm_tready;
        end
      end
    join
    sm_tready = 1'b1;
    wait_drain();
    axil_read(12'h000, 32'h6);
    $display("txn: wraparound sums with toggling sm_tready");

    // Writes while busy are ignored; length=0 completes with no beats
    axil_write(12'h010, 32'd5);
    axil_write(12'h000, 32'd1);
    sm_exp_q.push_back({1'b0, 32'd1});
    ss_push(32'd1);
    wait_drain();
    axil_write(12'h000, 32'd1);
    axil_write(12'h010, 32'd9);
    axil_read(12'h010, 32'd5);
    axil_read(12'h014, 32'd1);
    axil_read(12'h000, 32'h0);
    sm_exp_q.push_back({1'b0, 32'd2});
    sm_exp_q.push_back({1'b0, 32'd3});
    sm_exp_q.push_back({1'b0, 32'd4});
    sm_exp_q.push_back({1'b1, 32'd5});
    for (int i = 0; i < 4; i++) ss_push(32'd1);
    wait_drain();
    axil_read(12'h014, 32'd5);
    axil_read(12'h000, 32'h6);
    axil_write(12'h010, 32'd0);
    axil_write(12'h000, 32'd1);
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("len0_done", {31'b0, dut.ap_done_q}, 32'd1);
    @(posedge wb_clk_i); #1;
    axil_read(12'h000, 32'h6);
    axil_read(12'h014, 32'd0);
    $display("txn: busy writes ignored, length=0 run");

    // Asynchronous reset during a stalled run
    axil_write(12'h010, 32'd4);
    axil_write(12'h000, 32'd1);
    sm_tready = 1'b0;
    ss_push(32'd5);
    ss_push(32'd6);
    n = 0;
    do begin
      @(negedge wb_clk_i); n++;
    end while (!sm_tvalid && n < 20);
    if (!sm_tvalid) timeout("stalled_beat");
    @(posedge wb_clk_i); #2;
    wb_rst_i = 1'b1;
    #1;
    chk_reset_outs("midrun_reset");
    @(negedge wb_clk_i);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    sm_tready = 1'b1;
    @(posedge wb_clk_i); #1;
    axil_read(12'h000, 32'h4);
    axil_read(12'h014, 32'd0);
    axil_read(12'h010, 32'd0);
    axil_write(12'h010, 32'd1);
    axil_write(12'h000, 32'd1);
    sm_exp_q.push_back({1'b1, 32'd7});
    ss_push(32'd7);
    wait_drain();
    axil_read(12'h000, 32'h6);
    $display("txn: mid-run reset discards FIFO and run state");

    repeat (3) @(posedge wb_clk_i);
    if (rd_exp_q.size() != 0) timeout("rd_queue_drain");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/axil_axis_responder.md
Name: axil_axis_responder

Overview:
AXI4-Lite slave plus AXI-Stream slave/master endpoint. It is the responder for the Wishbone-to-AXI bridge's AXI-Lite master and stream ports, and serves as a programmable stand-in kernel for bridge bring-up. It holds the control and length registers, buffers ss words in a FIFO, and returns a running prefix sum on sm with tlast on the final word. Clock is wb_clk_i; reset is wb_rst_i, asynchronous, active-high.

Parameters:
pADDR_WIDTH, 12, AXI-Lite address width
pDATA_WIDTH, 32, AXI-Lite and stream data width
pFIFO_DEPTH, 8, ss input FIFO depth (power of 2, >=2)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  async active-high reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  pADDR_WIDTH  write address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  pDATA_WIDTH  write data
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  pADDR_WIDTH  read address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  pDATA_WIDTH  read data
ss_tvalid  in  1  input stream valid
ss_tready  out  1  input stream ready
ss_tdata  in  pDATA_WIDTH  input stream data
ss_tlast  in  1  input last (ignored)
sm_tvalid  out  1  output stream valid
sm_tready  in  1  output stream ready
sm_tdata  out  pDATA_WIDTH  output stream data
sm_tlast  out  1  output last

Behaviour:
- Reset values: awready=1, arready=1, wready=0, rvalid=0, rdata=0, ss_tready=1, sm_tvalid=0, sm_tdata=0, sm_tlast=0. ap_start=0, ap_done=0, ap_idle=1, length=0, FIFO empty, acc=0, count=0. Reset mid-transfer aborts everything and discards FIFO contents.
- Register map (byte address):
  - 0x00 ap_ctrl: bit0 ap_start (W1S), bit1 ap_done (RO, clear-on-read), bit2 ap_idle (RO).
  - 0x10 length (RW, 32 bits).
  - 0x14 out_count (RO, words emitted in the current or last run).
  - Other addresses: writes ignored, reads return 0.
- Write FSM W_ADDR -> W_DATA:
  - W_ADDR: awready=1. On awvalid, latch awaddr and go to W_DATA.
  - W_DATA: wready=1, asserted without waiting for wvalid. On wvalid, commit the write and return to W_ADDR.
  - Address and data phases are always sequential; awready=0 while in W_DATA.
- Read FSM R_ADDR -> R_DATA:
  - R_ADDR: arready=1. On arvalid, latch the register value into rdata and go to R_DATA.
  - R_DATA: rvalid=1, rdata held stable until rready; then rvalid=0, rdata=0, return to R_ADDR.
  - ap_done clears on the rvalid&rready handshake of an 0x00 read.
  - If ap_done is set in the same cycle as that clear, the set wins.
- ap_start write rules:
  - Accepted only when ap_idle=1; otherwise ignored.
  - A write of 0x10 while busy is ignored.
  - ap_start self-clears one cycle after it is set, when the engine leaves E_IDLE.
- ss FIFO:
  - ss_tready = !full.
  - Pushes are accepted in any engine state, so prefetch before ap_start is allowed.
  - A push and pop in the same cycle is legal; the count is unchanged.
  - When full, ss_tready=0 and the upstream holds its data.
- Engine FSM E_IDLE -> E_RUN -> E_DONE -> E_IDLE:
  - On ap_start: acc=0, count=0, ap_idle=0, ap_done=0. If length=0, go directly to E_DONE.
  - E_RUN pops when FIFO non-empty and (sm_tvalid=0 or sm_tready=1). On pop: acc_new = acc + data (mod 2^pDATA_WIDTH), sm_tdata=acc_new, sm_tvalid=1, sm_tlast=(count==length-1), count++.
  - sm_tvalid, sm_tdata and sm_tlast stay stable until sm_tready.
  - When the tlast beat handshakes, go to E_DONE.
  - E_DONE lasts one cycle: ap_done=1, ap_idle=1, go to E_IDLE.
  - Words in the FIFO beyond length remain for the next run.
- Latency: a ss word accepted at edge k with the engine in E_RUN and the output free appears on sm (sm_tvalid=1) after edge k+1. Throughput is 1 word/cycle with sm_tready held high.

Test Plan:
- AXI-Lite write 0x10=5, then read 0x10 -> awready/wready sequencing correct, rdata=5, rvalid held across 3 cycles of rready=0.
- length=4, ap_start, ss words 1,2,3,4 -> sm emits 1,3,6,10 with tlast on 10. Read 0x00 -> 0x6 (done|idle); the next read returns 0x4.
- Push 8 words before ap_start (pFIFO_DEPTH=8) -> ss_tready=0 on the 9th. Start with length=8 and sm_tready=1 -> 8 consecutive beats, no bubbles.
- sm_tready toggled 0/1 every cycle during length=3 with inputs 0xFFFFFFFF,1,2 -> outputs 0xFFFFFFFF,0,2, each stable while stalled.
- ap_start written while running, length written while running, length=0 start -> first two ignored (out_count unaffected); length=0 sets ap_done within 2 cycles with no sm beats.
- Assert wb_rst_i mid-run with sm_tvalid=1 -> all outputs return to reset values immediately; FIFO empty, ap_idle=1.
